// File: rtl/change_dispenser.sv
// Coin-payout sequencer for the vending machine hopper.
// Pays a change amount largest-coin-first (5 / 1 / 0.5 yuan) using one
// request/acknowledge handshake per coin, tracks per-tube inventory,
// reports shortfall and latches a sticky fault on hopper timeout.
module change_dispenser #(
  parameter int INV_W      = 8,
  parameter int INV5_INIT  = 20,
  parameter int INV1_INIT  = 50,
  parameter int INV05_INIT = 50,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       change,
  input  logic             hop_ack,
  input  logic             refill,
  input  logic [1:0]       refill_sel,
  output logic             busy,
  output logic             hop_req,
  output logic [1:0]       hop_sel,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [7:0]       remain,
  output logic [INV_W-1:0] inv_5,
  output logic [INV_W-1:0] inv_1,
  output logic [INV_W-1:0] inv_05
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  // Tube / denomination encoding shared by hop_sel and refill_sel
  localparam logic [1:0] SEL_05 = 2'b00;
  localparam logic [1:0] SEL_1  = 2'b01;
  localparam logic [1:0] SEL_5  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_FINISH,
    S_FAULT
  } state_t;

  state_t           state_reg;
  logic [7:0]       remain_reg;
  logic             busy_reg;
  logic             hop_req_reg;
  logic [1:0]       hop_sel_reg;
  logic             done_reg;
  logic             short_reg;
  logic             fault_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;

  // Tube counts, indexed by the tube encoding (0 = 0.5, 1 = 1, 2 = 5)
  logic [2:0][INV_W-1:0] inv_cnt;

  logic       ack_take;
  logic       pick_found;
  logic [1:0] pick_sel;

  // Coin value in 0.5-yuan units
  function automatic logic [7:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_5:   return 8'd10;
      SEL_1:   return 8'd2;
      default: return 8'd1;
    endcase
  endfunction

  // A coin is consumed only on an ack while a request is outstanding
  assign ack_take = (state_reg == S_REQ) && hop_ack;

  // Largest coin that fits into the remaining amount and is in stock
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = SEL_05;
    if (remain_reg >= 8'd10 && inv_cnt[2] != '0) begin
      pick_found = 1'b1;
      pick_sel   = SEL_5;
    end else if (remain_reg >= 8'd2 && inv_cnt[1] != '0) begin
      pick_found = 1'b1;
      pick_sel   = SEL_1;
    end else if (remain_reg >= 8'd1 && inv_cnt[0] != '0) begin
      pick_found = 1'b1;
      pick_sel   = SEL_05;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tube
      localparam int INIT_I = (gi == 2) ? INV5_INIT :
                              ((gi == 1) ? INV1_INIT : INV05_INIT);

      logic             inc;
      logic             dec;
      logic [INV_W-1:0] cnt_reg;

      assign inc = refill && (refill_sel == 2'(gi));
      assign dec = ack_take && (hop_sel_reg == 2'(gi));
      assign inv_cnt[gi] = cnt_reg;

      // Tube counter: saturating refill, decrement on paid coin, both cancel
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= INV_W'(INIT_I);
        end else if (inc && !dec) begin
          if (cnt_reg != '1) cnt_reg <= cnt_reg + INV_W'(1);
        end else if (dec && !inc) begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - INV_W'(1);
        end
      end
    end
  endgenerate

  // Payout sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      remain_reg  <= 8'd0;
      busy_reg    <= 1'b0;
      hop_req_reg <= 1'b0;
      hop_sel_reg <= SEL_05;
      done_reg    <= 1'b0;
      short_reg   <= 1'b0;
      fault_reg   <= 1'b0;
      tmo_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            remain_reg <= change;
            busy_reg   <= 1'b1;
            state_reg  <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (remain_reg == 8'd0) begin
            short_reg <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_FINISH;
          end else if (pick_found) begin
            hop_sel_reg <= pick_sel;
            hop_req_reg <= 1'b1;
            tmo_cnt_reg <= '0;
            state_reg   <= S_REQ;
          end else begin
            short_reg <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= S_FINISH;
          end
        end
        S_REQ: begin
          // An ack on the same edge as the timeout still counts as paid
          if (hop_ack) begin
            hop_req_reg <= 1'b0;
            remain_reg  <= remain_reg - coin_value(hop_sel_reg);
            state_reg   <= S_SELECT;
          end else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
            hop_req_reg <= 1'b0;
            busy_reg    <= 1'b0;
            fault_reg   <= 1'b1;
            state_reg   <= S_FAULT;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        S_FINISH: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        S_FAULT: begin
          state_reg <= S_FAULT;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign hop_req = hop_req_reg;
  assign hop_sel = hop_sel_reg;
  assign done    = done_reg;
  assign short   = short_reg;
  assign fault   = fault_reg;
  assign remain  = remain_reg;
  assign inv_05  = inv_cnt[0];
  assign inv_1   = inv_cnt[1];
  assign inv_5   = inv_cnt[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus
// randomized payouts against an arithmetic coin-count reference model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset, start, hop_ack, refill;
  logic [7:0] change;
  logic [1:0] refill_sel;
  logic       busy, hop_req, done, short, fault;
  logic [1:0] hop_sel;
  logic [7:0] remain, inv_5, inv_1, inv_05;

  // Second instance with a depleted 1-yuan tube and a single 0.5 coin
  logic       start_b, hop_ack_b;
  logic [7:0] change_b;
  logic       busy_b, hop_req_b, done_b, short_b, fault_b;
  logic [1:0] hop_sel_b;
  logic [7:0] remain_b, inv_5_b, inv_1_b, inv_05_b;

  int total = 0;
  int bad   = 0;

  // Reference inventory (0 = 0.5, 1 = 1, 2 = 5) and expected payout
  int m_inv[3];
  int exp_q[$];
  int exp_rem;
  int exp_short;
  int last_q[$];

  always #5 clk = ~clk;

  change_dispenser u_dut (
    .clk(clk), .reset(reset), .start(start), .change(change),
    .hop_ack(hop_ack), .refill(refill), .refill_sel(refill_sel),
    .busy(busy), .hop_req(hop_req), .hop_sel(hop_sel), .done(done),
    .short(short), .fault(fault), .remain(remain),
    .inv_5(inv_5), .inv_1(inv_1), .inv_05(inv_05)
  );

  change_dispenser #(.INV1_INIT(0), .INV05_INIT(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .change(change_b),
    .hop_ack(hop_ack_b), .refill(1'b0), .refill_sel(2'b00),
    .busy(busy_b), .hop_req(hop_req_b), .hop_sel(hop_sel_b), .done(done_b),
    .short(short_b), .fault(fault_b), .remain(remain_b),
    .inv_5(inv_5_b), .inv_1(inv_1_b), .inv_05(inv_05_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coin counts per denomination from plain division, capped by stock
  task automatic model_payout(input int chg);
    int rem, n5, n1, n05;
    rem = chg;
    n5  = (rem / 10 < m_inv[2]) ? rem / 10 : m_inv[2];
    rem = rem - 10 * n5;
    n1  = (rem / 2 < m_inv[1]) ? rem / 2 : m_inv[1];
    rem = rem - 2 * n1;
    n05 = (rem < m_inv[0]) ? rem : m_inv[0];
    rem = rem - n05;
    exp_q.delete();
    repeat (n5)  exp_q.push_back(2);
    repeat (n1)  exp_q.push_back(1);
    repeat (n05) exp_q.push_back(0);
    m_inv[2] -= n5;
    m_inv[1] -= n1;
    m_inv[0] -= n05;
    exp_rem   = rem;
    exp_short = (rem != 0) ? 1 : 0;
  endtask

  task automatic check_inv(input string tag);
    check({tag, "_inv5"},  inv_5,  m_inv[2]);
    check({tag, "_inv1"},  inv_1,  m_inv[1]);
    check({tag, "_inv05"}, inv_05, m_inv[0]);
  endtask

  task automatic do_refill(input int sel);
    refill = 1'b1;
    refill_sel = 2'(sel);
    tick();
    refill = 1'b0;
    if (sel < 3 && m_inv[sel] < 255) m_inv[sel]++;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!hop_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, hop_req, 1);
  endtask

  // One complete payout: random ack delays, optional spurious start/ack
  task automatic run_payout(input int chg, input int max_dly, input bit noise);
    int  got_q[$];
    int  dly;
    bit  seen_done;
    int  n;
    model_payout(chg);
    change = 8'(chg);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_on", busy, 1);
    check("remain_load", remain, chg);
    dly = -1;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      hop_ack = 1'b0;
      start = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (hop_req) begin
        if (dly < 0) begin
          dly = $urandom_range(0, max_dly);
          got_q.push_back(int'(hop_sel));
        end else begin
          check("sel_hold", hop_sel, got_q[$]);
        end
        if (dly == 0) begin
          hop_ack = 1'b1;
          dly = -1;
        end else begin
          dly--;
        end
      end else if (noise && $urandom_range(0, 3) == 0) begin
        hop_ack = 1'b1;
      end
      if (noise && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        change = 8'($urandom);
      end
      tick();
    end
    hop_ack = 1'b0;
    start = 1'b0;
    check("done_seen", seen_done, 1);
    check("short", short, exp_short);
    check("remain_end", remain, exp_rem);
    check("coin_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("coin_sel", got_q[i], exp_q[i]);
    check_inv("pay");
    last_q = got_q;
    tick();
    check("busy_off", busy, 0);
    check("done_off", done, 0);
    $display("payout change=%0d coins=%0d short=%0d remain=%0d inv=%0d/%0d/%0d",
             chg, got_q.size(), short, remain, inv_5, inv_1, inv_05);
  endtask

  initial begin
    int n;
    bit seen;
    reset = 1'b1; start = 1'b0; hop_ack = 1'b0; refill = 1'b0;
    change = 8'd0; refill_sel = 2'b00;
    start_b = 1'b0; hop_ack_b = 1'b0; change_b = 8'd0;
    m_inv[0] = 50; m_inv[1] = 50; m_inv[2] = 20;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_hop_req", hop_req, 0);
    check("rst_hop_sel", hop_sel, 0);
    check("rst_done", done, 0);
    check("rst_short", short, 0);
    check("rst_fault", fault, 0);
    check("rst_remain", remain, 0);
    check_inv("rst");
    $display("reset state checked");

    // 6.5 yuan with immediate acks: 5, 1, 0.5
    run_payout(13, 0, 1'b0);
    check("t13_n", last_q.size(), 3);
    if (last_q.size() == 3) begin
      check("t13_c0", last_q[0], 2);
      check("t13_c1", last_q[1], 1);
      check("t13_c2", last_q[2], 0);
    end
    check("t13_inv5", inv_5, 19);
    check("t13_inv1", inv_1, 49);
    check("t13_inv05", inv_05, 49);

    // Zero change: done two cycles after start, no request
    change = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("z_done_early", done, 0);
    check("z_req0", hop_req, 0);
    tick();
    check("z_done", done, 1);
    check("z_short", short, 0);
    check("z_req1", hop_req, 0);
    tick();
    check("z_done_off", done, 0);
    $display("zero change payout checked");

    // Refill of the 5-yuan tube on the same edge as a 5-yuan ack
    change = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_req("rf");
    check("rf_sel", hop_sel, 2);
    hop_ack = 1'b1;
    refill = 1'b1;
    refill_sel = 2'b10;
    tick();
    hop_ack = 1'b0;
    refill = 1'b0;
    check("rf_inv5", inv_5, m_inv[2]);
    check("rf_remain", remain, 0);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    check("rf_done", done, 1);
    check("rf_short", short, 0);
    tick();
    $display("refill+ack collision inv_5=%0d", inv_5);

    // Randomized payouts with refills in between
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 3)) do_refill($urandom_range(0, 3));
      check_inv("refill");
      run_payout($urandom_range(0, 80), 3, 1'b1);
    end

    // Saturation of the 0.5 tube
    while (m_inv[0] < 255) do_refill(0);
    repeat (10) do_refill(0);
    check("sat_inv05", inv_05, 255);
    check_inv("sat");
    $display("saturation inv_05=%0d", inv_05);

    // Reset while a request is outstanding
    change = 8'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_req("mr");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_inv[0] = 50; m_inv[1] = 50; m_inv[2] = 20;
    check("mr_req", hop_req, 0);
    check("mr_busy", busy, 0);
    check("mr_remain", remain, 0);
    check_inv("mr");
    $display("mid-payout reset checked");

    // Hopper never acknowledges: fault after TIMEOUT request cycles
    change = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !fault; c++) begin
      if (hop_req) n++;
      if (done) seen = 1'b1;
      tick();
    end
    check("to_req_cycles", n, 15);
    check("to_fault", fault, 1);
    check("to_req_low", hop_req, 0);
    check("to_busy", busy, 0);
    check("to_no_done", seen, 0);
    change = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("to_start_ign", busy, 0);
    check("to_req_ign", hop_req, 0);
    check("to_fault_hold", fault, 1);
    do_refill(1);
    check("to_refill", inv_1, m_inv[1]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_inv[0] = 50; m_inv[1] = 50; m_inv[2] = 20;
    check("to_fault_clr", fault, 0);
    $display("timeout fault checked");

    // Second instance: 2 yuan owed, only one 0.5 coin available
    change_b = 8'd4;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      hop_ack_b = 1'b0;
      if (done_b) begin
        seen = 1'b1;
        break;
      end
      if (hop_req_b) begin
        n++;
        check("b_sel", hop_sel_b, 0);
        hop_ack_b = 1'b1;
      end
      tick();
    end
    hop_ack_b = 1'b0;
    check("b_done", seen, 1);
    check("b_coins", n, 1);
    check("b_short", short_b, 1);
    check("b_remain", remain_b, 3);
    check("b_inv05", inv_05_b, 0);
    $display("shortfall payout coins=%0d short=%0d remain=%0d", n, short_b, remain_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
